// File: rtl/mem_responder.sv
// mem_responder
//   Target side of the processor memory port. Accepts a request (address,
//   write data, write enable, RAM/ROM select). After a fixed number of wait
//   states it returns read data with a one-cycle Ready pulse. It owns a
//   DEPTH x DATA_W data RAM and fronts an external instruction ROM through
//   romAddr/romQ.
//
// Ports
//   Clock    in   rising-edge clock
//   Resetn   in   asynchronous active-low reset
//   Req      in   request strobe, sampled only in IDLE or RESP
//   Sel      in   1 = RAM, 0 = ROM
//   W        in   1 = write, 0 = read
//   ADDR     in   16-bit word address; only [ADDR_W-1:0] selects a word
//   WDATA    in   write data
//   RDATA    out  response data, valid only while Ready = 1
//   Ready    out  one-cycle response pulse
//   Busy     out  1 while in WAIT or RESP
//   Err      out  error flag, qualified by Ready
//   romAddr  out  address to the external ROM, held from IDLE exit through RESP
//   romQ     in   ROM data for romAddr
module mem_responder #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 16,
  parameter int RAM_WAIT = 1,
  parameter int ROM_WAIT = 2
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Req,
  input  logic              Sel,
  input  logic              W,
  input  logic [15:0]       ADDR,
  input  logic [DATA_W-1:0] WDATA,
  output logic [DATA_W-1:0] RDATA,
  output logic              Ready,
  output logic              Busy,
  output logic              Err,
  output logic [ADDR_W-1:0] romAddr,
  input  logic [DATA_W-1:0] romQ
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [3:0]        cnt;
  logic              sel_q;
  logic              w_q;
  logic              err_q;
  logic [DATA_W-1:0] wdata_q;

  logic              accept;
  logic              complete;
  logic              req_err;
  logic              ram_we;
  logic [DATA_W-1:0] resp_data;

  logic [DATA_W-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Control decode and next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    accept     = 1'b0;
    complete   = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (Req) begin
          accept     = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // Req is ignored here: a request arriving while busy is dropped.
        if (cnt == 4'd0) begin
          complete   = 1'b1;
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (Req) begin
          accept     = 1'b1;
          state_next = S_WAIT;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // A write to ROM or any address bit above the RAM range makes the access
  // an error: it runs with normal latency but returns 0 and writes nothing.
  assign req_err = (!Sel && W) || (ADDR[15:ADDR_W] != '0);

  assign ram_we = complete && sel_q && w_q && !err_q;

  always_comb begin
    resp_data = '0;
    if (!err_q) begin
      if (!sel_q)   resp_data = romQ;
      else if (w_q) resp_data = wdata_q;
      else          resp_data = mem[romAddr];
    end
  end

  assign Busy = (state != S_IDLE);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Request latch, wait counter and registered response
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt     <= 4'd0;
      sel_q   <= 1'b0;
      w_q     <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      romAddr <= '0;
      RDATA   <= '0;
      Ready   <= 1'b0;
      Err     <= 1'b0;
    end else begin
      if (accept) begin
        sel_q   <= Sel;
        w_q     <= W;
        err_q   <= req_err;
        wdata_q <= WDATA;
        // The latched address doubles as the RAM index, so romAddr stays
        // stable for the whole access even when the target is RAM.
        romAddr <= ADDR[ADDR_W-1:0];
        cnt     <= Sel ? 4'(RAM_WAIT) : 4'(ROM_WAIT);
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      Ready <= complete;
      Err   <= complete && err_q;
      RDATA <= complete ? resp_data : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Data RAM
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; contents survive Resetn, and a reset
  // branch would stop the array from mapping onto RAM blocks.
  always_ff @(posedge Clock) begin
    if (ram_we) mem[romAddr] <= wdata_q;
  end

endmodule
